// File: rtl/noc_router_xy_sync_pkg.sv
// rtl/noc_router_xy_sync_pkg.sv - shared port enum, XY route and round-robin helpers
// Contents: port_e (N,E,S,W,PE), NUM_PORTS, route(), rr_grant(), next_ptr()
package noc_router_pkg;

  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    P_N  = 3'd0,
    P_E  = 3'd1,
    P_S  = 3'd2,
    P_W  = 3'd3,
    P_PE = 3'd4
  } port_e;

  // Dimension-ordered: resolve X first, then Y, then eject locally.
  function automatic port_e route(input logic [31:0] dst_x, input logic [31:0] dst_y,
                                  input logic [31:0] my_x, input logic [31:0] my_y);
    if (dst_x > my_x)      return P_E;
    else if (dst_x < my_x) return P_W;
    else if (dst_y > my_y) return P_N;
    else if (dst_y < my_y) return P_S;
    else                   return P_PE;
  endfunction

  // First requester at or after ptr, wrapping 4 -> 0; one-hot result.
  function automatic logic [NUM_PORTS-1:0] rr_grant(input logic [NUM_PORTS-1:0] req,
                                                   input logic [2:0] ptr);
    logic [NUM_PORTS-1:0] gnt;
    logic                 found;
    logic [2:0]           idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = 3'((int'(ptr) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Pointer moves one past the winner so the winner has lowest priority next time.
  function automatic logic [2:0] next_ptr(input logic [NUM_PORTS-1:0] gnt);
    logic [2:0] nxt;
    nxt = 3'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) nxt = (i == NUM_PORTS - 1) ? 3'd0 : 3'(i + 1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/noc_router_xy_sync_if.sv
// rtl/noc_router_xy_sync_if.sv - five-lane flit bus (data/valid/ready per port)
// master drives data,valid and samples ready; slave the reverse
interface noc_router_xy_sync_if
  import noc_router_pkg::*;
#(
  parameter int WIDTH = 35
);
  logic [NUM_PORTS-1:0][WIDTH-1:0] data;
  logic [NUM_PORTS-1:0]            valid;
  logic [NUM_PORTS-1:0]            ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/noc_router_xy_sync_fifo.sv
// rtl/noc_router_xy_sync_fifo.sv - per-port input flit FIFO (DEPTH power of two)
// Ports: clk, rst_n, push, pop, wdata, rdata (head), empty, full, count
module noc_router_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/noc_router_xy_sync.sv
// rtl/noc_router_xy_sync.sv - five-port XY mesh router with RR arbiters and registered outputs
// Ports: clk, rst_n (async, active low), in_bus (slave: flits in), out_bus (master: flits out)
// Port order on both buses: 0=N 1=E 2=S 3=W 4=PE
module noc_router_xy_sync
  import noc_router_pkg::*;
#(
  parameter int WIDTH = 35,
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int DEPTH = 4,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noc_router_xy_sync_if.slave   in_bus,
  noc_router_xy_sync_if.master  out_bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]                head  [NUM_PORTS];
  logic [CNT_W-1:0]                count [NUM_PORTS];
  port_e                           route_sel [NUM_PORTS];
  logic [NUM_PORTS-1:0]            empty, full, push, pop;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req, grant;
  logic [NUM_PORTS-1:0][WIDTH-1:0] sel_data;
  logic [NUM_PORTS-1:0][WIDTH-1:0] data_q;
  logic [NUM_PORTS-1:0]            valid_q;
  logic [NUM_PORTS-1:0][2:0]       ptr;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    // Ready comes from the registered count only, so out_ready never reaches in_ready.
    assign in_bus.ready[i] = (count[i] != CNT_W'(DEPTH));
    assign push[i]         = in_bus.valid[i] && !full[i];

    noc_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (in_bus.data[i]),
      .rdata (head[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .count (count[i])
    );

    assign route_sel[i] = route(32'(head[i][WIDTH-1 -: X_W]),
                                32'(head[i][WIDTH-1-X_W -: Y_W]),
                                32'(MY_X), 32'(MY_Y));
  end

  // Arbitration, pop and load select all come from registered heads plus out_ready.
  always_comb begin
    req      = '0;
    grant    = '0;
    pop      = '0;
    sel_data = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = !empty[i] && (route_sel[i] == port_e'(3'(o)));
      end
      if (!valid_q[o] || out_bus.ready[o]) begin
        grant[o] = rr_grant(req[o], ptr[o]);
      end
      // Each input requests a single output, so OR-ing grants never double-pops.
      pop = pop | grant[o];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[o][i]) sel_data[o] = head[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      ptr     <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (|grant[o]) begin
          data_q[o]  <= sel_data[o];
          valid_q[o] <= 1'b1;
          ptr[o]     <= next_ptr(grant[o]);
        end else if (out_bus.ready[o]) begin
          valid_q[o] <= 1'b0;
        end
      end
    end
  end

  assign out_bus.data  = data_q;
  assign out_bus.valid = valid_q;
endmodule

// File: tb/tb_noc_router_xy_sync.sv
// tb/tb_noc_router_xy_sync.sv - self-checking bench for noc_router_xy_sync at MY=(1,1)
module tb_noc_router_xy_sync;
  import noc_router_pkg::*;

  localparam int WIDTH = 35;
  localparam int X_W   = 2;
  localparam int Y_W   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  noc_router_xy_sync_if #(.WIDTH(WIDTH)) in_bus ();
  noc_router_xy_sync_if #(.WIDTH(WIDTH)) out_bus ();

  noc_router_xy_sync #(
    .WIDTH(WIDTH), .X_W(X_W), .Y_W(Y_W), .DEPTH(DEPTH), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_bus  (in_bus),
    .out_bus (out_bus)
  );

  int total = 0;
  int bad   = 0;

  logic [4:0] src_en;
  int seq [5];
  int dx  [5];
  int dy  [5];

  typedef struct {
    int port;
    int x;
    int y;
    int exp_out;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flit: dst_x, dst_y, zero pad, 3-bit source port, 8-bit sequence number.
  function automatic logic [WIDTH-1:0] mk(input int x, input int y, input int src, input int sq);
    return {x[1:0], y[1:0], 20'd0, src[2:0], sq[7:0]};
  endfunction

  // Drive from bench state, take one edge, and advance a source's sequence when accepted.
  task automatic tick();
    logic [4:0] rdy;
    logic [4:0] val;
    for (int i = 0; i < 5; i++) begin
      in_bus.valid[i] = src_en[i];
      in_bus.data[i]  = mk(dx[i], dy[i], i, seq[i]);
    end
    rdy = in_bus.ready;
    val = in_bus.valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (val[i] && rdy[i]) seq[i]++;
    end
  endtask

  task automatic do_reset();
    src_en       = '0;
    in_bus.valid = '0;
    rst_n        = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_bus.valid), 64'(0));
    chk("rst_in_ready", 64'(in_bus.ready), 64'(5'h1f));
    chk("rst_out_data_zero", 64'(|out_bus.data), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) seq[i] = 0;
  endtask

  initial begin
    logic [WIDTH-1:0] f;
    int src_of_out [5];
    int order [4];
    int got;
    int s;

    rst_n         = 1'b0;
    src_en        = '0;
    in_bus.valid  = '0;
    in_bus.data   = '0;
    out_bus.ready = 5'h1f;
    for (int i = 0; i < 5; i++) begin
      seq[i] = 0;
      dx[i]  = 1;
      dy[i]  = 1;
    end

    // 1: reset at start, then again mid-stream.
    do_reset();
    src_en = 5'h1f;
    for (int c = 0; c < 3; c++) tick();
    do_reset();

    // 1+2: single flits, table-driven.
    vecs[0] = '{port: 4, x: 3, y: 1, exp_out: 1};
    vecs[1] = '{port: 3, x: 0, y: 2, exp_out: 3};
    vecs[2] = '{port: 3, x: 1, y: 2, exp_out: 0};
    vecs[3] = '{port: 3, x: 1, y: 0, exp_out: 2};
    vecs[4] = '{port: 3, x: 1, y: 1, exp_out: 4};
    vecs[5] = '{port: 3, x: 2, y: 0, exp_out: 1};
    for (int v = 0; v < 6; v++) begin
      dx[vecs[v].port] = vecs[v].x;
      dy[vecs[v].port] = vecs[v].y;
      f      = mk(vecs[v].x, vecs[v].y, vecs[v].port, seq[vecs[v].port]);
      src_en = 5'(1 << vecs[v].port);
      tick();
      src_en = '0;
      tick();
      chk($sformatf("route%0d_valid", v), 64'(out_bus.valid), 64'(1 << vecs[v].exp_out));
      chk($sformatf("route%0d_data", v), 64'(out_bus.data[vecs[v].exp_out]), 64'(f));
      tick();
      chk($sformatf("route%0d_drain", v), 64'(out_bus.valid), 64'(0));
    end

    // 3: N, S, W, PE all stream to E.
    do_reset();
    order = '{0, 2, 3, 4};
    for (int i = 0; i < 5; i++) begin
      dx[i] = 2;
      dy[i] = 1;
    end
    got    = 0;
    src_en = 5'b11101;
    tick();
    tick();
    for (int c = 0; c < 12; c++) begin
      s = int'(out_bus.data[1][10:8]);
      chk($sformatf("fair%0d_valid", c), 64'(out_bus.valid[1]), 64'(1));
      chk($sformatf("fair%0d_src", c), 64'(s), 64'(order[c % 4]));
      chk($sformatf("fair%0d_seq", c), 64'(out_bus.data[1][7:0]), 64'(c / 4));
      tick();
    end

    // 4: back-pressure on PE with N -> PE.
    do_reset();
    dx[0] = 1;
    dy[0] = 1;
    out_bus.ready = 5'b01111;
    for (int c = 0; c < 8; c++) begin
      src_en = (seq[0] < 5) ? 5'b00001 : 5'b00000;
      tick();
      if (c >= 2) chk($sformatf("bp_hold%0d", c), 64'(out_bus.data[4]), 64'(mk(1, 1, 0, 0)));
    end
    src_en = '0;
    chk("bp_accepted", 64'(seq[0]), 64'(5));
    chk("bp_in_ready_low", 64'(in_bus.ready[0]), 64'(0));
    chk("bp_out_valid", 64'(out_bus.valid[4]), 64'(1));
    out_bus.ready = 5'h1f;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_bus.valid[4]) begin
        chk($sformatf("bp_flit%0d", got), 64'(out_bus.data[4]), 64'(mk(1, 1, 0, got)));
        got++;
      end
      tick();
    end
    chk("bp_delivered", 64'(got), 64'(5));

    // 5: five disjoint paths, all injecting every cycle.
    do_reset();
    dx = '{1, 0, 1, 2, 1};
    dy = '{0, 1, 2, 1, 1};
    src_of_out = '{2, 3, 0, 1, 4};
    src_en = 5'h1f;
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("par%0d_valid", c), 64'(out_bus.valid), 64'(5'h1f));
      chk($sformatf("par%0d_in_ready", c), 64'(in_bus.ready), 64'(5'h1f));
      for (int o = 0; o < 5; o++) begin
        s = src_of_out[o];
        chk($sformatf("par%0d_out%0d", c, o), 64'(out_bus.data[o]), 64'(mk(dx[s], dy[s], s, c)));
      end
      tick();
    end

    // 6: reset while every FIFO is full and outputs are stalled.
    do_reset();
    out_bus.ready = '0;
    src_en = 5'h1f;
    for (int c = 0; c < 8; c++) tick();
    chk("full_in_ready", 64'(in_bus.ready), 64'(0));
    chk("full_out_valid", 64'(out_bus.valid), 64'(5'h1f));
    do_reset();
    out_bus.ready = 5'h1f;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("post_rst%0d_quiet", c), 64'(out_bus.valid), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
